output_buffer: RTL and testbench
================================

Name: output_buffer

Overview:
Store-side peripheral block of the LSU. It holds the memory-mapped output registers for the red LEDs, green LEDs, eight 7-segment digits and the character LCD, and drives them to the board pins. It supports byte-masked RV32I stores and combinational load read-back. An LCD enable-strobe sequencer generates the EN pulse timing in hardware, so software issues a single store per LCD command or character.

Parameters:
LCD_SETUP_CYC, 4, cycles EN stays low with RS/RW/data stable before the pulse (must be >=1)
LCD_PULSE_CYC, 25, cycles EN is held high (must be >=1)
LCD_HOLD_CYC, 4, cycles EN stays low after the pulse before the next command is accepted (must be >=1)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, synchronous, active-low
i_st_en  in  1  store strobe; the address is already decoded to the output region
i_addr  in  16  byte address; i_addr[7:4] selects the register
i_st_data  in  32  store data, lane-aligned
i_bmask  in  4  byte-lane write mask; bit k enables bits [8k+7:8k]
o_ld_data  out  32  combinational read-back of the selected register
o_io_ledr  out  32  red LED register
o_io_ledg  out  32  green LED register
o_io_hex0..o_io_hex7  out  7 each  7-segment digit outputs
o_io_lcd  out  32  LCD pins: [31] ON, [10] EN, [9] RS, [8] RW, [7:0] DATA, all other bits 0
o_lcd_busy  out  1  LCD sequencer active

Behaviour:
- Register map (i_addr[7:4]): 0=LEDR, 1=LEDG, 2=HEX0..3 (byte k maps to digit k), 3=HEX4..7, 4=LCD, 5..F unmapped.
- Reset: when i_rst_n=0 at a rising edge, all registers clear to 0, the FSM returns to IDLE, and EN, busy and overrun clear. A reset during an LCD transaction aborts it, and EN is low from the next cycle.
- Stores: at a rising edge with i_st_en=1, each lane whose i_bmask bit is set is written. Stores to unmapped addresses are ignored and reads from them return 0.
- HEX: each byte keeps bits [6:0]. Bit 7 is discarded and reads back as 0.
- Load: o_ld_data is a zero-latency combinational mux. LCD read-back is {ON, 18'b0, overrun[12], busy[11], EN[10], RS, RW, DATA}.
- LCD store while IDLE: lanes 0, 1 and 3 latch. If i_bmask[0]=1, a transaction starts and the FSM enters SETUP on the next cycle. A store with i_bmask[0]=0 updates ON/RS/RW only and starts nothing.
- LCD store while busy: the entire store is dropped (including ON) and the sticky overrun bit sets. Overrun clears on reset or on the next accepted LCD store.
- FSM: IDLE -> SETUP -> PULSE -> HOLD -> IDLE.
  - SETUP lasts LCD_SETUP_CYC cycles, PULSE lasts LCD_PULSE_CYC, HOLD lasts LCD_HOLD_CYC.
  - Each state loads a counter with N-1 on entry and transitions when the counter reaches 0.
  - EN=1 only in PULSE. o_lcd_busy=1 in SETUP, PULSE and HOLD, for a total of S+P+H cycles.
  - Counter width is $clog2 of the largest parameter, plus 1.
- Simultaneous events: a store accepted in the same cycle that HOLD ends is treated as busy and dropped. The FSM must reach IDLE first.

Optional Feature:
OUTPUT_BUFFER_HEX_DECODE_EN
- Defined: each HEX byte stores only its low nibble. Outputs are the active-low 7-segment decode in gfedcba order, 0-F (0x40, 0x79, 0x24, 0x30, ... 0x0E). Read-back returns {4'b0, nibble} per byte.
- Undefined: raw 7-bit pass-through as described in Behaviour.

Decomposition:
- Package output_buffer_pkg holds:
  - region constants (ADDR_LEDR=4'h0 ... ADDR_LCD=4'h4);
  - LCD bit-position localparams (LCD_ON=31, LCD_OVR=12, LCD_BUSY=11, LCD_EN=10, LCD_RS=9, LCD_RW=8);
  - enum lcd_state_e {IDLE, SETUP, PULSE, HOLD};
  - function hex_decode(nibble) -> 7-bit pattern.
- One sub-module, lcd_strobe_fsm. Inputs: start, params. Outputs: en, busy.

Test Plan:
1. Hold i_rst_n=0 for 2 cycles -> all o_io_* = 0, o_lcd_busy = 0, o_ld_data = 0 for every address.
2. Store 0xDEADBEEF to 0x00 with mask 1111, then 0x00005500 with mask 0010 -> o_io_ledr = 0xDEAD55EF, read-back 0xDEAD55EF, LEDG unchanged at 0.
3. Store 0x80000241 to 0x40 with mask 1111 at default parameters:
   - busy=1 on the next cycle;
   - EN high for exactly 25 cycles beginning 4 cycles after busy rises;
   - busy falls after 33 cycles;
   - o_io_lcd[7:0] = 0x41 and RS = 1 throughout.
4. Store 0x00000242 to 0x40 during PULSE -> DATA stays 0x41, read-back bit 12 = 1. A later store while idle clears bit 12 and launches a new pulse.
5. Assert reset in cycle 10 of PULSE -> next edge: EN = 0, busy = 0, o_io_lcd = 0. Store 0xFFFFFFFF to 0x50 -> no register changes.
6. HEX: store 0xFF7F063F to 0x20 -> hex0 = 0x3F, hex1 = 0x06, hex2 = 0x7F, hex3 = 0x7F. With OUTPUT_BUFFER_HEX_DECODE_EN, storing 0x00000003 -> hex0 = 0x30, read-back 0x00000003.

Source files
------------

// File: rtl/output_buffer_pkg.sv
// -----------------------------------------------------------------------------
// output_buffer_pkg
// Shared definitions for the LSU output-peripheral block:
//   - register-region selectors (i_addr[7:4])
//   - bit positions of the LCD pin / read-back word
//   - LCD strobe sequencer state encoding
//   - hex_decode(): nibble -> active-low 7-segment pattern (gfedcba)
// -----------------------------------------------------------------------------
package output_buffer_pkg;

  localparam logic [3:0] ADDR_LEDR   = 4'h0;
  localparam logic [3:0] ADDR_LEDG   = 4'h1;
  localparam logic [3:0] ADDR_HEX_LO = 4'h2;
  localparam logic [3:0] ADDR_HEX_HI = 4'h3;
  localparam logic [3:0] ADDR_LCD    = 4'h4;

  localparam int LCD_ON   = 31;
  localparam int LCD_OVR  = 12;
  localparam int LCD_BUSY = 11;
  localparam int LCD_EN   = 10;
  localparam int LCD_RS   = 9;
  localparam int LCD_RW   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } lcd_state_e;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_decode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/output_buffer_lcd_strobe_fsm.sv
// -----------------------------------------------------------------------------
// lcd_strobe_fsm
// Generates the character-LCD EN strobe for one command/character:
//   IDLE -> SETUP (SETUP_CYC) -> PULSE (PULSE_CYC, en=1) -> HOLD (HOLD_CYC) -> IDLE
// Each timed state loads its counter with N-1 on entry and leaves when the
// counter reaches 0.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset (aborts a transaction)
//   start  begin a transaction (only honoured in IDLE)
//   en     LCD EN pin, high only in PULSE
//   busy   high in SETUP, PULSE and HOLD
// -----------------------------------------------------------------------------
module lcd_strobe_fsm
  import output_buffer_pkg::*;
#(
  parameter int SETUP_CYC = 4,
  parameter int PULSE_CYC = 25,
  parameter int HOLD_CYC  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic en,
  output logic busy
);

  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

  lcd_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    en        = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETUP;
          cnt_nxt   = SETUP_LOAD;
        end
      end
      SETUP: begin
        busy = 1'b1;
        if (cnt == '0) begin
          state_nxt = PULSE;
          cnt_nxt   = PULSE_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      PULSE: begin
        busy = 1'b1;
        en   = 1'b1;
        if (cnt == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HOLD: begin
        // Still busy on the final HOLD cycle, so a store landing on that
        // edge is dropped; the FSM has to be seen in IDLE first.
        busy = 1'b1;
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/output_buffer.sv
// -----------------------------------------------------------------------------
// output_buffer
// Store-side peripheral block of the LSU: memory-mapped output registers for
// red/green LEDs, eight 7-segment digits and the character LCD, with byte-
// masked stores and combinational load read-back. Region = i_addr[7:4]:
//   0 LEDR, 1 LEDG, 2 HEX0..3, 3 HEX4..7, 4 LCD, 5..F unmapped (read 0).
// Optional build macro OUTPUT_BUFFER_HEX_DECODE_EN: HEX bytes keep only their
// low nibble and the digit outputs are the active-low 7-segment decode.
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_st_en, i_addr           store strobe, byte address
//   i_st_data, i_bmask        lane-aligned store data, byte-lane mask
//   o_ld_data                 combinational read-back of selected register
//   o_io_ledr, o_io_ledg      LED registers
//   o_io_hex0..o_io_hex7      7-segment digit outputs
//   o_io_lcd                  {ON[31], EN[10], RS[9], RW[8], DATA[7:0]}
//   o_lcd_busy                LCD strobe sequencer active
// -----------------------------------------------------------------------------
module output_buffer
  import output_buffer_pkg::*;
#(
  parameter int LCD_SETUP_CYC = 4,
  parameter int LCD_PULSE_CYC = 25,
  parameter int LCD_HOLD_CYC  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_st_en,
  input  logic [15:0] i_addr,
  input  logic [31:0] i_st_data,
  input  logic [3:0]  i_bmask,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex0,
  output logic [6:0]  o_io_hex1,
  output logic [6:0]  o_io_hex2,
  output logic [6:0]  o_io_hex3,
  output logic [6:0]  o_io_hex4,
  output logic [6:0]  o_io_hex5,
  output logic [6:0]  o_io_hex6,
  output logic [6:0]  o_io_hex7,
  output logic [31:0] o_io_lcd,
  output logic        o_lcd_busy
);

  logic [3:0]  sel;
  logic        unused_addr;
  logic [31:0] ledr, ledg;
  logic [6:0]  hex [8];
  logic [6:0]  hex_out [8];
  logic        lcd_on, lcd_rs, lcd_rw, overrun;
  logic [7:0]  lcd_data;
  logic        lcd_en, lcd_busy;
  logic        lcd_wr, lcd_accept, lcd_start;

  assign sel         = i_addr[7:4];
  assign unused_addr = ^{i_addr[15:8], i_addr[3:0]};

  // A busy sequencer drops the whole store; only an idle store is accepted,
  // and only one that writes the DATA lane launches a strobe.
  assign lcd_wr     = i_st_en && (sel == ADDR_LCD);
  assign lcd_accept = lcd_wr && !lcd_busy;
  assign lcd_start  = lcd_accept && i_bmask[0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ledr     <= '0;
      ledg     <= '0;
      for (int k = 0; k < 8; k++) hex[k] <= '0;
      lcd_on   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_rw   <= 1'b0;
      lcd_data <= '0;
      overrun  <= 1'b0;
    end else if (i_st_en) begin
      for (int k = 0; k < 4; k++) begin
        if (i_bmask[k]) begin
          if (sel == ADDR_LEDR) ledr[8*k +: 8] <= i_st_data[8*k +: 8];
          if (sel == ADDR_LEDG) ledg[8*k +: 8] <= i_st_data[8*k +: 8];
`ifdef OUTPUT_BUFFER_HEX_DECODE_EN
          if (sel == ADDR_HEX_LO) hex[k]   <= {3'b000, i_st_data[8*k +: 4]};
          if (sel == ADDR_HEX_HI) hex[k+4] <= {3'b000, i_st_data[8*k +: 4]};
`else
          if (sel == ADDR_HEX_LO) hex[k]   <= i_st_data[8*k +: 7];
          if (sel == ADDR_HEX_HI) hex[k+4] <= i_st_data[8*k +: 7];
`endif
        end
      end
      if (lcd_accept) begin
        if (i_bmask[0]) lcd_data <= i_st_data[7:0];
        if (i_bmask[1]) begin
          lcd_rs <= i_st_data[LCD_RS];
          lcd_rw <= i_st_data[LCD_RW];
        end
        if (i_bmask[3]) lcd_on <= i_st_data[LCD_ON];
      end
      if (lcd_wr) overrun <= lcd_busy;
    end
  end

  lcd_strobe_fsm #(
    .SETUP_CYC (LCD_SETUP_CYC),
    .PULSE_CYC (LCD_PULSE_CYC),
    .HOLD_CYC  (LCD_HOLD_CYC)
  ) u_lcd_strobe_fsm (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .start (lcd_start),
    .en    (lcd_en),
    .busy  (lcd_busy)
  );

  for (genvar k = 0; k < 8; k++) begin : g_hex
`ifdef OUTPUT_BUFFER_HEX_DECODE_EN
    assign hex_out[k] = hex_decode(hex[k][3:0]);
`else
    assign hex_out[k] = hex[k];
`endif
  end

  assign o_io_ledr  = ledr;
  assign o_io_ledg  = ledg;
  assign o_io_hex0  = hex_out[0];
  assign o_io_hex1  = hex_out[1];
  assign o_io_hex2  = hex_out[2];
  assign o_io_hex3  = hex_out[3];
  assign o_io_hex4  = hex_out[4];
  assign o_io_hex5  = hex_out[5];
  assign o_io_hex6  = hex_out[6];
  assign o_io_hex7  = hex_out[7];
  assign o_lcd_busy = lcd_busy;

  always_comb begin
    o_io_lcd         = '0;
    o_io_lcd[LCD_ON] = lcd_on;
    o_io_lcd[LCD_EN] = lcd_en;
    o_io_lcd[LCD_RS] = lcd_rs;
    o_io_lcd[LCD_RW] = lcd_rw;
    o_io_lcd[7:0]    = lcd_data;
  end

  always_comb begin
    o_ld_data = '0;
    case (sel)
      ADDR_LEDR:   o_ld_data = ledr;
      ADDR_LEDG:   o_ld_data = ledg;
      ADDR_HEX_LO: o_ld_data = {1'b0, hex[3], 1'b0, hex[2], 1'b0, hex[1], 1'b0, hex[0]};
      ADDR_HEX_HI: o_ld_data = {1'b0, hex[7], 1'b0, hex[6], 1'b0, hex[5], 1'b0, hex[4]};
      ADDR_LCD: begin
        o_ld_data           = o_io_lcd;
        o_ld_data[LCD_OVR]  = overrun;
        o_ld_data[LCD_BUSY] = lcd_busy;
      end
      default: o_ld_data = '0;
    endcase
  end

endmodule

// File: tb/tb_output_buffer.sv
// -----------------------------------------------------------------------------
// tb_output_buffer
// Directed, table-driven bench for output_buffer at default LCD timing
// (setup 4, pulse 25, hold 4), plus hand-written LCD sequences.
// -----------------------------------------------------------------------------
module tb_output_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_en;
  logic [15:0] addr;
  logic [31:0] st_data;
  logic [3:0]  bmask;
  logic [31:0] ld_data, ledr, ledg, lcd;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic        busy;

  int checks = 0;
  int errors = 0;

  output_buffer dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_st_en    (st_en),
    .i_addr     (addr),
    .i_st_data  (st_data),
    .i_bmask    (bmask),
    .o_ld_data  (ld_data),
    .o_io_ledr  (ledr),
    .o_io_ledg  (ledg),
    .o_io_hex0  (hex0),
    .o_io_hex1  (hex1),
    .o_io_hex2  (hex2),
    .o_io_hex3  (hex3),
    .o_io_hex4  (hex4),
    .o_io_hex5  (hex5),
    .o_io_hex6  (hex6),
    .o_io_hex7  (hex7),
    .o_io_lcd   (lcd),
    .o_lcd_busy (busy)
  );

  always #5 clk = ~clk;

  localparam int CHK_LD   = 0;
  localparam int CHK_LEDR = 1;
  localparam int CHK_LEDG = 2;
  localparam int CHK_HLO  = 3;
  localparam int CHK_HHI  = 4;
  localparam int CHK_LCD  = 5;
  localparam int CHK_BUSY = 6;

`ifdef OUTPUT_BUFFER_HEX_DECODE_EN
  localparam logic [31:0] HLO_PINS = 32'h0E0E020E;
  localparam logic [31:0] HLO_RB   = 32'h0F0F060F;
  localparam logic [31:0] HHI_PINS = 32'h00000030;
`else
  localparam logic [31:0] HLO_PINS = 32'h7F7F063F;
  localparam logic [31:0] HLO_RB   = 32'h7F7F063F;
  localparam logic [31:0] HHI_PINS = 32'h00000003;
`endif

  typedef struct {
    logic        st;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  bm;
    int          chk;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic store(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
    addr    = a;
    st_data = d;
    bmask   = m;
    st_en   = 1'b1;
    tick();
    st_en   = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] observe(input int chk);
    case (chk)
      CHK_LD:   return ld_data;
      CHK_LEDR: return ledr;
      CHK_LEDG: return ledg;
      CHK_HLO:  return {1'b0, hex3, 1'b0, hex2, 1'b0, hex1, 1'b0, hex0};
      CHK_HHI:  return {1'b0, hex7, 1'b0, hex6, 1'b0, hex5, 1'b0, hex4};
      CHK_LCD:  return lcd;
      default:  return {31'b0, busy};
    endcase
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check(name, {31'b0, busy}, 32'h0);
  endtask

  initial begin
    int en_first, en_cnt, busy_cnt;
    bit pins_ok, done;

    vecs[0]  = '{1'b1, 16'h0000, 32'hDEADBEEF, 4'b1111, CHK_LEDR, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 16'h0000, 32'h00005500, 4'b0010, CHK_LEDR, 32'hDEAD55EF};
    vecs[2]  = '{1'b0, 16'h0000, 32'h0,        4'b0000, CHK_LD,   32'hDEAD55EF};
    vecs[3]  = '{1'b0, 16'h0010, 32'h0,        4'b0000, CHK_LEDG, 32'h00000000};
    vecs[4]  = '{1'b1, 16'h0010, 32'h12345678, 4'b0101, CHK_LEDG, 32'h00340078};
    vecs[5]  = '{1'b0, 16'h0010, 32'h0,        4'b0000, CHK_LD,   32'h00340078};
    vecs[6]  = '{1'b1, 16'h0020, 32'hFF7F063F, 4'b1111, CHK_HLO,  HLO_PINS};
    vecs[7]  = '{1'b0, 16'h0020, 32'h0,        4'b0000, CHK_LD,   HLO_RB};
    vecs[8]  = '{1'b1, 16'h0034, 32'h00000003, 4'b0001, CHK_HHI,  HHI_PINS};
    vecs[9]  = '{1'b0, 16'h0030, 32'h0,        4'b0000, CHK_LD,   32'h00000003};
    vecs[10] = '{1'b1, 16'h0050, 32'hFFFFFFFF, 4'b1111, CHK_LEDR, 32'hDEAD55EF};
    vecs[11] = '{1'b0, 16'h0050, 32'h0,        4'b0000, CHK_LD,   32'h00000000};
    vecs[12] = '{1'b0, 16'h00F0, 32'h0,        4'b0000, CHK_LD,   32'h00000000};
    vecs[13] = '{1'b1, 16'h0000, 32'hFFFFFFFF, 4'b0000, CHK_LEDR, 32'hDEAD55EF};
    vecs[14] = '{1'b1, 16'h0040, 32'h80000300, 4'b1010, CHK_LCD,  32'h80000300};
    vecs[15] = '{1'b0, 16'h0040, 32'h0,        4'b0000, CHK_BUSY, 32'h00000000};
    vecs[16] = '{1'b0, 16'h0040, 32'h0,        4'b0000, CHK_LD,   32'h80000300};

    rst_n   = 1'b0;
    st_en   = 1'b0;
    addr    = '0;
    st_data = '0;
    bmask   = '0;

    // Reset state
    tick();
    tick();
    check("rst_ledr", ledr, 32'h0);
    check("rst_ledg", ledg, 32'h0);
    check("rst_hex_lo", observe(CHK_HLO), 32'h0);
    check("rst_hex_hi", observe(CHK_HHI), 32'h0);
    check("rst_lcd", lcd, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    for (int a = 0; a < 16; a++) begin
      addr = 16'(a << 4);
      #1;
      check($sformatf("rst_ld_%0h", a), ld_data, 32'h0);
    end
    rst_n = 1'b1;
    tick();

    // Table-driven register vectors
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].st) begin
        store(vecs[i].addr, vecs[i].data, vecs[i].bm);
      end else begin
        addr = vecs[i].addr;
        #1;
      end
      check($sformatf("vec%0d", i), observe(vecs[i].chk), vecs[i].exp);
    end

    // Full LCD strobe: busy next cycle, EN 25 cycles starting 4 in, 33 busy
    store(16'h0040, 32'h80000241, 4'b1111);
    check("lcd_busy_rise", {31'b0, busy}, 32'h1);
    en_first = -1;
    en_cnt   = 0;
    busy_cnt = 0;
    pins_ok  = 1'b1;
    done     = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      busy_cnt++;
      if (lcd[10]) begin
        if (en_first < 0) en_first = i;
        en_cnt++;
      end
      if (lcd[7:0] != 8'h41 || lcd[9] != 1'b1 || lcd[31] != 1'b1) pins_ok = 1'b0;
      tick();
    end
    check("lcd_done", {31'b0, done}, 32'h1);
    check("lcd_busy_cycles", busy_cnt, 32'd33);
    check("lcd_en_start", en_first, 32'd4);
    check("lcd_en_cycles", en_cnt, 32'd25);
    check("lcd_pins_stable", {31'b0, pins_ok}, 32'h1);

    // Store during PULSE is dropped and sets overrun
    store(16'h0040, 32'h80000241, 4'b1111);
    for (int i = 0; i < 6; i++) tick();
    store(16'h0040, 32'h00000242, 4'b1111);
    check("ovr_data_kept", {24'b0, lcd[7:0]}, 32'h41);
    check("ovr_on_kept", {31'b0, lcd[31]}, 32'h1);
    check("ovr_bit_set", {31'b0, ld_data[12]}, 32'h1);
    check("ovr_rb_busy", {31'b0, ld_data[11]}, 32'h1);
    wait_idle("ovr_wait_idle");
    check("ovr_sticky", {31'b0, ld_data[12]}, 32'h1);

    // Accepted idle store clears overrun and launches a new pulse
    store(16'h0040, 32'h00000243, 4'b0001);
    check("relaunch_busy", {31'b0, busy}, 32'h1);
    check("relaunch_ovr_clr", {31'b0, ld_data[12]}, 32'h0);
    check("relaunch_data", {24'b0, lcd[7:0]}, 32'h43);
    check("relaunch_on_kept", {31'b0, lcd[31]}, 32'h1);

    // Store landing on the edge that ends HOLD is still dropped
    for (int i = 0; i < 32; i++) tick();
    check("hold_last_busy", {31'b0, busy}, 32'h1);
    store(16'h0040, 32'h00000255, 4'b1111);
    check("hold_end_idle", {31'b0, busy}, 32'h0);
    check("hold_end_ovr", {31'b0, ld_data[12]}, 32'h1);
    check("hold_end_data", {24'b0, lcd[7:0]}, 32'h43);

    // Reset in the tenth PULSE cycle aborts the transaction
    store(16'h0040, 32'h00000244, 4'b0001);
    for (int i = 0; i < 13; i++) tick();
    check("pre_rst_en", {31'b0, lcd[10]}, 32'h1);
    rst_n = 1'b0;
    tick();
    check("abort_en", {31'b0, lcd[10]}, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_lcd", lcd, 32'h0);
    check("abort_ledr", ledr, 32'h0);
    check("abort_hex_lo", observe(CHK_HLO), 32'h0);
    rst_n = 1'b1;
    tick();

    // Unmapped store changes nothing
    store(16'h0050, 32'hFFFFFFFF, 4'b1111);
    check("unmapped_ledr", ledr, 32'h0);
    check("unmapped_ledg", ledg, 32'h0);
    check("unmapped_lcd", lcd, 32'h0);
    check("unmapped_busy", {31'b0, busy}, 32'h0);
    check("unmapped_ld", ld_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
